// File: rtl/operand_read_stage.sv
// Register-read stage: per-lane FSM that reads the PRF one cycle after issue, merges same-cycle CDB
// writes captured at accept, and holds merged operands while the functional unit stalls.
module operand_read_stage #(
  parameter  int LANES     = 5,
  parameter  int P_REG_NUM = 64,
  parameter  int PAYLOAD_W = 64,
  parameter  int DATA_W    = 32,
  localparam int PREG_W    = $clog2(P_REG_NUM),
  localparam int CDB_NUM   = LANES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 iss_valid   [LANES],
  output logic                 iss_ready   [LANES],
  input  logic [PREG_W-1:0]    iss_ps1     [LANES],
  input  logic [PREG_W-1:0]    iss_ps2     [LANES],
  input  logic [PAYLOAD_W-1:0] iss_payload [LANES],
  output logic [PREG_W-1:0]    prf_rs1_s   [LANES],
  output logic [PREG_W-1:0]    prf_rs2_s   [LANES],
  input  logic [DATA_W-1:0]    prf_rs1_v   [LANES],
  input  logic [DATA_W-1:0]    prf_rs2_v   [LANES],
  input  logic                 cdb_we      [CDB_NUM],
  input  logic [PREG_W-1:0]    cdb_pd      [CDB_NUM],
  input  logic [DATA_W-1:0]    cdb_val     [CDB_NUM],
  output logic                 ex_valid    [LANES],
  input  logic                 ex_ready    [LANES],
  output logic [DATA_W-1:0]    ex_rs1_v    [LANES],
  output logic [DATA_W-1:0]    ex_rs2_v    [LANES],
  output logic [PAYLOAD_W-1:0] ex_payload  [LANES]
);

  typedef enum logic [1:0] {S_EMPTY, S_READ, S_HOLD} state_t;

  // Returns {hit, value}. p0 is forced to a zero-valued hit so the PRF read is ignored for it.
  function automatic logic [DATA_W:0] cdb_match(input logic [PREG_W-1:0] ps);
    logic [DATA_W:0] res;
    res = '0;
    if (ps == '0) begin
      res = {1'b1, {DATA_W{1'b0}}};
    end else begin
      for (int k = CDB_NUM - 1; k >= 0; k--) begin
        if (cdb_we[k] && (cdb_pd[k] == ps)) res = {1'b1, cdb_val[k]};
      end
    end
    return res;
  endfunction

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    state_t                r_state, w_state_nxt;
    logic                  w_accept, w_iss_ready, w_ex_valid;
    logic [DATA_W:0]       w_match1_p0, w_match2_p0;
    logic                  r_hit1_p1, r_hit2_p1;
    logic [DATA_W-1:0]     r_byp1_p1, r_byp2_p1;
    logic [PAYLOAD_W-1:0]  r_payload_p1;
    logic [DATA_W-1:0]     w_op1_p1, w_op2_p1;
    logic [DATA_W-1:0]     r_op1_p2, r_op2_p2;
    logic [DATA_W-1:0]     w_ex1, w_ex2;

    // p0: issue acceptance, PRF index drive and CDB snoop
    always_comb begin
      w_iss_ready = !rst && !flush && ((r_state == S_EMPTY) || ex_ready[l]);
      w_accept    = iss_valid[l] && w_iss_ready;
      w_match1_p0 = cdb_match(iss_ps1[l]);
      w_match2_p0 = cdb_match(iss_ps2[l]);
    end

    assign iss_ready[l] = w_iss_ready;
    assign prf_rs1_s[l] = w_accept ? iss_ps1[l] : '0;
    assign prf_rs2_s[l] = w_accept ? iss_ps2[l] : '0;

    always_comb begin
      w_state_nxt = r_state;
      w_ex_valid  = !rst && (r_state != S_EMPTY);
      w_op1_p1    = r_hit1_p1 ? r_byp1_p1 : prf_rs1_v[l];
      w_op2_p1    = r_hit2_p1 ? r_byp2_p1 : prf_rs2_v[l];
      w_ex1       = '0;
      w_ex2       = '0;
      case (r_state)
        S_EMPTY: if (w_accept) w_state_nxt = S_READ;
        S_READ: begin
          w_ex1 = w_op1_p1;
          w_ex2 = w_op2_p1;
          if (ex_ready[l]) w_state_nxt = w_accept ? S_READ : S_EMPTY;
          else             w_state_nxt = S_HOLD;
        end
        S_HOLD: begin
          w_ex1 = r_op1_p2;
          w_ex2 = r_op2_p2;
          if (ex_ready[l]) w_state_nxt = w_accept ? S_READ : S_EMPTY;
        end
        default: w_state_nxt = S_EMPTY;
      endcase
      if (flush) w_state_nxt = S_EMPTY;
    end

    assign ex_valid[l]   = w_ex_valid;
    assign ex_rs1_v[l]   = w_ex1;
    assign ex_rs2_v[l]   = w_ex2;
    assign ex_payload[l] = r_payload_p1;

    always_ff @(posedge clk) begin
      if (rst) r_state <= S_EMPTY;
      else     r_state <= w_state_nxt;
    end

    // p1: captured issue data; p2: merged operands frozen for a stalled FU
    always_ff @(posedge clk) begin
      if (rst) begin
        r_hit1_p1    <= 1'b0;
        r_hit2_p1    <= 1'b0;
        r_byp1_p1    <= '0;
        r_byp2_p1    <= '0;
        r_payload_p1 <= '0;
        r_op1_p2     <= '0;
        r_op2_p2     <= '0;
      end else begin
        if (w_accept) begin
          r_hit1_p1    <= w_match1_p0[DATA_W];
          r_hit2_p1    <= w_match2_p0[DATA_W];
          r_byp1_p1    <= w_match1_p0[DATA_W-1:0];
          r_byp2_p1    <= w_match2_p0[DATA_W-1:0];
          r_payload_p1 <= iss_payload[l];
        end
        if ((r_state == S_READ) && !ex_ready[l]) begin
          r_op1_p2 <= w_op1_p1;
          r_op2_p2 <= w_op2_p1;
        end
      end
    end
  end

endmodule

// File: tb/tb_operand_read_stage.sv
// Bench for operand_read_stage: behavioural PRF with registered read and no write-through,
// plus a per-lane scoreboard of expected operands/payload filled at issue and drained at FU consume.
module tb_operand_read_stage;
  localparam int L  = 5;
  localparam int PW = 6;
  localparam int DW = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, flush, mem_ld;
  logic          iss_valid [L], iss_ready [L];
  logic [PW-1:0] iss_ps1 [L], iss_ps2 [L];
  logic [DW-1:0] iss_payload [L];
  logic [PW-1:0] prf_rs1_s [L], prf_rs2_s [L];
  logic [31:0]   prf_rs1_v [L], prf_rs2_v [L];
  logic          cdb_we [L];
  logic [PW-1:0] cdb_pd [L];
  logic [31:0]   cdb_val [L];
  logic          ex_valid [L], ex_ready [L];
  logic [31:0]   ex_rs1_v [L], ex_rs2_v [L];
  logic [DW-1:0] ex_payload [L];

  operand_read_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_ps1(iss_ps1), .iss_ps2(iss_ps2),
    .iss_payload(iss_payload), .prf_rs1_s(prf_rs1_s), .prf_rs2_s(prf_rs2_s),
    .prf_rs1_v(prf_rs1_v), .prf_rs2_v(prf_rs2_v), .cdb_we(cdb_we), .cdb_pd(cdb_pd),
    .cdb_val(cdb_val), .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_rs1_v(ex_rs1_v),
    .ex_rs2_v(ex_rs2_v), .ex_payload(ex_payload)
  );

  function automatic logic [31:0] init_val(input int i);
    if (i == 5) return 32'h11;
    if (i == 7) return 32'h22;
    return 32'h1000 + i;
  endfunction

  // PRF model: read data registered one cycle, writes land at the same edge (old value read back)
  logic [31:0] mem [64];
  always @(posedge clk) begin
    if (mem_ld) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_val(i);
    end else begin
      for (int k = 0; k < L; k++) if (cdb_we[k]) mem[cdb_pd[k]] <= cdb_val[k];
    end
    for (int l = 0; l < L; l++) begin
      prf_rs1_v[l] <= mem[prf_rs1_s[l]];
      prf_rs2_v[l] <= mem[prf_rs2_s[l]];
    end
  end

  typedef struct {
    logic [31:0]   a;
    logic [31:0]   b;
    logic [DW-1:0] p;
  } exp_t;
  exp_t sb [L][$];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_op(input logic [PW-1:0] ps);
    if (ps == 0) return 32'h0;
    for (int k = 0; k < L; k++) if (cdb_we[k] && cdb_pd[k] == ps) return cdb_val[k];
    return mem[ps];
  endfunction

  task automatic idle();
    flush = 1'b0;
    for (int l = 0; l < L; l++) begin
      iss_valid[l] = 1'b0; iss_ps1[l] = '0; iss_ps2[l] = '0; iss_payload[l] = '0;
      ex_ready[l] = 1'b1; cdb_we[l] = 1'b0; cdb_pd[l] = '0; cdb_val[l] = '0;
    end
  endtask

  // Called at a negedge with inputs already driven; checks this cycle, then advances one clock.
  task automatic step();
    #1;
    for (int l = 0; l < L; l++) begin
      logic mr, acc;
      exp_t e;
      mr  = !rst && !flush && (sb[l].size() == 0 || ex_ready[l]);
      acc = iss_valid[l] && mr;
      chk($sformatf("iss_ready[%0d]", l), 64'(iss_ready[l]), 64'(mr));
      chk($sformatf("prf_rs1_s[%0d]", l), 64'(prf_rs1_s[l]), acc ? 64'(iss_ps1[l]) : 64'h0);
      chk($sformatf("prf_rs2_s[%0d]", l), 64'(prf_rs2_s[l]), acc ? 64'(iss_ps2[l]) : 64'h0);
      if (sb[l].size() > 0) begin
        chk($sformatf("ex_valid[%0d]", l), 64'(ex_valid[l]), 64'(!rst));
        if (!rst) begin
          e = sb[l][0];
          chk($sformatf("ex_rs1_v[%0d]", l), 64'(ex_rs1_v[l]), 64'(e.a));
          chk($sformatf("ex_rs2_v[%0d]", l), 64'(ex_rs2_v[l]), 64'(e.b));
          chk($sformatf("ex_payload[%0d]", l), ex_payload[l], e.p);
          if (ex_ready[l]) void'(sb[l].pop_front());
        end
      end else begin
        chk($sformatf("ex_valid_idle[%0d]", l), 64'(ex_valid[l]), 64'h0);
      end
      if (acc) begin
        e.a = exp_op(iss_ps1[l]);
        e.b = exp_op(iss_ps2[l]);
        e.p = iss_payload[l];
        sb[l].push_back(e);
      end
    end
    @(posedge clk);
    if (rst || flush) for (int l = 0; l < L; l++) sb[l].delete();
    @(negedge clk);
  endtask

  initial begin
    idle();
    rst = 1'b1; mem_ld = 1'b1;
    @(negedge clk);
    // reset: no acceptance, no valid, zero indices even with an offered uop
    iss_valid[0] = 1'b1; iss_ps1[0] = 6'd3;
    step();
    mem_ld = 1'b0;
    step();
    rst = 1'b0; idle();
    step();
    chk("rst_ex_rs1_v", 64'(ex_rs1_v[0]), 64'h0);
    chk("rst_ex_payload", ex_payload[0], 64'h0);

    // basic read, latency 1
    iss_valid[0] = 1'b1; iss_ps1[0] = 6'd5; iss_ps2[0] = 6'd7; iss_payload[0] = 64'hA1;
    step(); idle();
    chk("t1_valid", 64'(ex_valid[0]), 64'h1);
    chk("t1_rs1", 64'(ex_rs1_v[0]), 64'h11);
    chk("t1_rs2", 64'(ex_rs2_v[0]), 64'h22);
    step();

    // same-cycle CDB bypass beats stale PRF; lowest CDB index wins
    iss_valid[0] = 1'b1; iss_ps1[0] = 6'd9; iss_ps2[0] = 6'd5; iss_payload[0] = 64'hA2;
    iss_valid[1] = 1'b1; iss_ps1[1] = 6'd7; iss_ps2[1] = 6'd9; iss_payload[1] = 64'hA3;
    cdb_we[2] = 1'b1; cdb_pd[2] = 6'd9; cdb_val[2] = 32'hDEAD;
    cdb_we[4] = 1'b1; cdb_pd[4] = 6'd9; cdb_val[4] = 32'h4444;
    step(); idle();
    chk("t2_byp", 64'(ex_rs1_v[0]), 64'hDEAD);
    chk("t2_lowk", 64'(ex_rs2_v[1]), 64'hDEAD);
    step();

    // p0 is never bypassed
    iss_valid[0] = 1'b1; iss_ps1[0] = 6'd0; iss_ps2[0] = 6'd5; iss_payload[0] = 64'hA4;
    cdb_we[0] = 1'b1; cdb_pd[0] = 6'd0; cdb_val[0] = 32'hFF;
    step(); idle();
    chk("t3_p0", 64'(ex_rs1_v[0]), 64'h0);
    step();

    // FU stall for 3 cycles, then resume with a back-to-back issue
    iss_valid[1] = 1'b1; iss_ps1[1] = 6'd5; iss_ps2[1] = 6'd7; iss_payload[1] = 64'hB4;
    ex_ready[1] = 1'b0;
    step();
    for (int c = 0; c < 3; c++) begin
      idle();
      ex_ready[1] = 1'b0; iss_valid[1] = 1'b1; iss_ps1[1] = 6'd3; iss_payload[1] = 64'hBB;
      cdb_we[0] = 1'b1; cdb_pd[0] = 6'd5; cdb_val[0] = 32'h5555;
      #1;
      chk("t4_stall_ready", 64'(iss_ready[1]), 64'h0);
      chk("t4_stall_valid", 64'(ex_valid[1]), 64'h1);
      chk("t4_stall_rs1", 64'(ex_rs1_v[1]), 64'h11);
      chk("t4_stall_pay", ex_payload[1], 64'hB4);
      step();
    end
    idle();
    iss_valid[1] = 1'b1; iss_ps1[1] = 6'd7; iss_ps2[1] = 6'd0; iss_payload[1] = 64'hB5;
    step(); idle();
    chk("t4_b2b_valid", 64'(ex_valid[1]), 64'h1);
    chk("t4_b2b_pay", ex_payload[1], 64'hB5);
    chk("t4_b2b_rs1", 64'(ex_rs1_v[1]), 64'h22);
    step();

    // all lanes back-to-back
    for (int c = 0; c < 4; c++) begin
      for (int l = 0; l < L; l++) begin
        iss_valid[l] = 1'b1;
        iss_ps1[l] = 6'($urandom_range(0, 63));
        iss_ps2[l] = 6'($urandom_range(0, 63));
        iss_payload[l] = {32'(c), 32'(l)};
      end
      step();
    end
    idle();
    chk("t5_last_pay", ex_payload[4], {32'd3, 32'd4});
    step();

    // flush with lanes in HOLD and READ
    iss_valid[2] = 1'b1; iss_ps1[2] = 6'd5; iss_payload[2] = 64'hC2; ex_ready[2] = 1'b0;
    step(); idle();
    ex_ready[2] = 1'b0;
    iss_valid[3] = 1'b1; iss_ps1[3] = 6'd7; iss_payload[3] = 64'hC3; ex_ready[3] = 1'b0;
    step(); idle();
    ex_ready[2] = 1'b0; ex_ready[3] = 1'b0; flush = 1'b1;
    iss_valid[0] = 1'b1; iss_ps1[0] = 6'd5; iss_payload[0] = 64'hC0;
    #1;
    chk("t6_flush_ready", 64'(iss_ready[0]), 64'h0);
    chk("t6_flush_v2", 64'(ex_valid[2]), 64'h1);
    chk("t6_flush_v3", 64'(ex_valid[3]), 64'h1);
    step(); idle();
    for (int l = 0; l < L; l++) chk($sformatf("t6_after[%0d]", l), 64'(ex_valid[l]), 64'h0);
    step();

    // random traffic with stalls, CDB hits and occasional flush
    for (int c = 0; c < 60; c++) begin
      flush = ($urandom_range(0, 19) == 0);
      for (int l = 0; l < L; l++) begin
        iss_valid[l] = 1'($urandom_range(0, 1));
        iss_ps1[l] = 6'($urandom_range(0, 15));
        iss_ps2[l] = 6'($urandom_range(0, 15));
        iss_payload[l] = {32'(c), 32'($urandom)};
        ex_ready[l] = ($urandom_range(0, 3) != 0);
        cdb_we[l] = 1'($urandom_range(0, 1));
        cdb_pd[l] = 6'($urandom_range(0, 15));
        cdb_val[l] = $urandom;
      end
      step();
    end
    idle();
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
